// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the FFT bit-reversal reorder buffer: bit-reversed input side, natural-order output side.
// FFT_REORDER_LAST_EN adds in_last / frame_err to the bundle.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef FFT_REORDER_LAST_EN
  logic              in_last;
  logic              frame_err;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef FFT_REORDER_LAST_EN
    input  in_last,
    output frame_err,
`endif
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef FFT_REORDER_LAST_EN
    output in_last,
    input  frame_err,
`endif
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes FFT samples to bit-reversed addresses, streams frames out in natural order.
// Optional feature macro FFT_REORDER_LAST_EN: in_last framing check with sticky frame_err.
module fft_bitrev_reorder #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 6
) (
  input logic                  clk,
  input logic                  rst,
  fft_bitrev_reorder_if.slave  bus
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_ONE = 1;

  logic [DATA_W-1:0] bank0_q [N];
  logic [DATA_W-1:0] bank1_q [N];

  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_acc, rd_acc, wr_last, rd_last;
`ifdef FFT_REORDER_LAST_EN
  logic             frame_err_q, frame_err_d;
`endif

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  assign bus.in_ready  = !full_q[wb_q];
  assign bus.out_valid = full_q[rb_q];
  assign bus.out_data  = rb_q ? bank1_q[rd_cnt_q] : bank0_q[rd_cnt_q];
  assign bus.out_last  = full_q[rb_q] && rd_last;

  assign wr_acc  = bus.in_valid && bus.in_ready;
  assign rd_acc  = bus.out_valid && bus.out_ready;
  assign wr_last = &wr_cnt_q;
  assign rd_last = &rd_cnt_q;
  assign wr_addr = bitrev(wr_cnt_q);
`ifdef FFT_REORDER_LAST_EN
  assign bus.frame_err = frame_err_q;
`endif

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    full_d   = full_q;
`ifdef FFT_REORDER_LAST_EN
    frame_err_d = frame_err_q;
`endif
    // A set and a clear can never hit the same bank in one cycle, so both updates apply in order.
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
`ifdef FFT_REORDER_LAST_EN
      if (bus.in_last && !wr_last) begin
        frame_err_d = 1'b1;
        wr_cnt_d    = '0;
      end
      if (!bus.in_last && wr_last) frame_err_d = 1'b1;
`endif
    end
    if (rd_acc) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
      if (rd_last) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
`ifdef FFT_REORDER_LAST_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      full_q   <= full_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
`ifdef FFT_REORDER_LAST_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // Sample storage survives reset; only the pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (wb_q) bank1_q[wr_addr] <= bus.in_data;
      else      bank0_q[wr_addr] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder against a frame-level queue model.
// Builds with or without FFT_REORDER_LAST_EN.
module tb_fft_bitrev_reorder;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_W(32)) bus ();

  fft_bitrev_reorder #(.DATA_W(32), .LOG2N(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending output samples in the order they must leave.
  logic [31:0] exp_q[$];
  logic [31:0] frame_buf [N];
  int          wr_k  = 0;
  logic        err_m = 1'b0;

  // Stimulus generator state
  int          send_left  = 0;
  int          pv = 100, pr = 100;
  int          gen_k = 0, gen_f = 0;
  bit          rand_mode  = 1'b0;
  bit          force_frag = 1'b0;
  logic [31:0] gen_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic void next_data();
    gen_data = rand_mode ? $urandom : 32'(N * gen_f + brev(gen_k));
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic l);
    frame_buf[wr_k] = d;
`ifdef FFT_REORDER_LAST_EN
    if (l && wr_k != N-1) begin
      err_m = 1'b1;
      wr_k  = 0;
      return;
    end
    if (!l && wr_k == N-1) err_m = 1'b1;
`endif
    if (wr_k == N-1) begin
      // Sample k sits at natural address brev(k), so natural index n holds sample brev(n).
      for (int n = 0; n < N; n++) exp_q.push_back(frame_buf[brev(n)]);
      wr_k = 0;
    end else begin
      wr_k++;
    end
  endfunction

  task automatic step();
    logic iv, ordy, il, e_rdy, e_vld, e_last;
    @(negedge clk);
    iv   = (send_left > 0) && ($urandom_range(99) < pv);
    ordy = $urandom_range(99) < pr;
    il   = force_frag ? (gen_k == 9) : (gen_k == N-1);
    bus.in_valid  = iv;
    bus.in_data   = gen_data;
    bus.out_ready = ordy;
`ifdef FFT_REORDER_LAST_EN
    bus.in_last   = il;
`endif
    #1;
    e_rdy  = exp_q.size() <= N;
    e_vld  = exp_q.size() > 0;
    e_last = (exp_q.size() % N) == 1;
    check("in_ready", bus.in_ready, e_rdy);
    check("out_valid", bus.out_valid, e_vld);
    check("out_last", bus.out_last, e_last);
    if (e_vld) check("out_data", bus.out_data, exp_q[0]);
`ifdef FFT_REORDER_LAST_EN
    check("frame_err", bus.frame_err, err_m);
`endif
    if (e_vld && ordy) void'(exp_q.pop_front());
    if (iv && e_rdy) begin
      model_accept(gen_data, il);
      send_left--;
      gen_k = (gen_k + 1) % N;
      if (gen_k == 0) gen_f++;
      next_data();
    end
  endtask

  task automatic drain(input int bound);
    int c = 0;
    while ((send_left > 0 || exp_q.size() > 0) && c < bound) begin
      step();
      c++;
    end
    check("drain_done", 32'(send_left == 0 && exp_q.size() == 0), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_last", bus.out_last, 1'b0);
`ifdef FFT_REORDER_LAST_EN
    check("rst_frame_err", bus.frame_err, 1'b0);
`endif
    exp_q.delete();
    wr_k  = 0;
    err_m = 1'b0;
    gen_k = 0;
    next_data();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef FFT_REORDER_LAST_EN
    bus.in_last   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    do_reset();

    // Single frame: in_data = bitrev(k) comes out as 0..63
    gen_f = 0; next_data();
    pv = 100; pr = 100; send_left = N;
    drain(400);

    // Streaming: four back-to-back frames
    gen_k = 0; gen_f = 1; next_data();
    send_left = 4 * N;
    drain(1000);

    // Backpressure: third frame stalls until the output side opens
    gen_f = 10; gen_k = 0; next_data();
    pr = 0; send_left = 3 * N;
    repeat (200) step();
    check("bp_stalled_left", 32'(send_left), 32'(N));
    pr = 100;
    drain(1000);

    // Random stalls on both sides, random data, 20 frames
    rand_mode = 1'b1; next_data();
    pv = 50; pr = 50; send_left = 20 * N;
    drain(20000);

    // Reset with one full frame queued and a 30-sample partial frame pending
    pv = 100; pr = 0; send_left = N + 30;
    repeat (N + 40) step();
    do_reset();
    pr = 100; send_left = N;
    drain(400);

`ifdef FFT_REORDER_LAST_EN
    // Early in_last on the 10th sample discards the fragment; the clean frame follows
    gen_k = 0; force_frag = 1'b1; next_data();
    send_left = 10;
    drain(200);
    force_frag = 1'b0;
    gen_k = 0; next_data();
    send_left = N;
    drain(400);
    check("frame_err_sticky", bus.frame_err, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Reorder buffer at the output of the 64-point FFT core. The core emits each frame in bit-reversed order. This block accepts those samples over a valid/ready stream and writes sample k to natural address bitrev(k). It then streams the frame out in natural order 0..N-1. A two-bank ping-pong memory lets one frame drain while the next fills.

## Interface
- `DATA_W`, 32, sample width (packed {re[15:0], im[15:0]}); passed through unmodified
- `LOG2N`, 6, log2 of frame length; N = 2^LOG2N = 64
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `in_valid`  in  1  input sample present
- `in_ready`  out  1  block can accept a sample this cycle
- `in_data`  in  DATA_W  input sample, bit-reversed order
- `out_valid`  out  1  output sample present
- `out_ready`  in  1  downstream accepts output this cycle
- `out_data`  out  DATA_W  output sample, natural order
- `out_last`  out  1  high with sample index N-1 of each output frame
- `frame_err`  out  1  sticky framing error; exists only with `FFT_REORDER_LAST_EN`
- `in_last`  in  1  last input sample of frame; exists only with `FFT_REORDER_LAST_EN`

## Operation
- Storage: two banks of N x DATA_W registers (`bank0`, `bank1`), plus per-bank flag `full[1:0]`.
- Write side:
  - Pointers: bank pointer `wb` (1 bit) and counter `wr_cnt` (LOG2N bits).
  - `in_ready = !full[wb]`.
  - Accept when `in_valid && in_ready`: write `in_data` to `bank[wb][bitrev(wr_cnt)]`, then increment `wr_cnt`.
  - bitrev is a full LOG2N-bit reversal: bit i maps to bit LOG2N-1-i.
  - Accept at `wr_cnt == N-1`: `wr_cnt` wraps to 0, `full[wb]` is set, `wb` toggles.
- Read side:
  - Pointers: bank pointer `rb` and counter `rd_cnt`.
  - `out_valid = full[rb]`.
  - `out_data = bank[rb][rd_cnt]`; the read is combinational from registers.
  - `out_last = out_valid && rd_cnt == N-1`.
  - Transfer when `out_valid && out_ready`: increment `rd_cnt`.
  - Transfer at N-1: `rd_cnt` wraps to 0, `full[rb]` clears, `rb` toggles.
- Per-bank state: EMPTY (`full=0`, not being written), FILLING (`full=0`, `wb` points here, `wr_cnt>0`), FULL/DRAINING (`full=1`).
- Transitions:
  - FILLING -> FULL on the last write.
  - FULL -> EMPTY on the last read.
- Simultaneous events:
  - Last write to bank A and last read from bank B in the same cycle: both take effect.
  - A set and a clear never target the same bank in the same cycle, because a bank is never both `wb` with `full=0` and `rb` with `full=1`.
- Both banks full: `in_ready=0`. The stream stalls with no data loss.
- `in_valid` dropping mid-frame: `wr_cnt` holds. A partial frame stays pending indefinitely.
- Reset, at any time including mid-frame:
  - Cleared to 0: `wb`, `rb`, `wr_cnt`, `rd_cnt`, `full`.
  - Partial frames are discarded; bank contents are not cleared.

## Timing
- Reset values:
  - `in_ready=1`
  - `out_valid=0`
  - `out_last=0`
  - `frame_err=0`
  - `out_data` = X-free don't-care; the bench ignores it while `out_valid=0`.
- Latency: last input accepted at edge t -> `out_valid=1` in the cycle after edge t; natural index 0 is presented then.
- Throughput: one sample per clock sustained in and out simultaneously. No bubbles at frame boundaries on either side.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.

## Configuration
- `FFT_REORDER_LAST_EN` defined: adds the `in_last` input and the `frame_err` output.
  - `in_last=1` on an accepted sample with `wr_cnt != N-1`: set `frame_err`, discard the partial frame (`wr_cnt` <- 0, `wb` unchanged, `full` unchanged).
  - `in_last=0` on an accepted sample with `wr_cnt == N-1`: set `frame_err`; the frame still completes normally.
  - `frame_err` clears only on `rst`.
- Not defined: `in_last` and `frame_err` ports are absent. Framing is purely by count.

## Test plan
- Single frame:
  - Stimulus: reset, then feed `in_data = bitrev(k)` for k = 0..63, back-to-back, with `out_ready=1`.
  - Response: `out_data` = 0,1,...,63 in order; `out_valid` rises the cycle after the 64th accept; `out_last` only with 63.
- Streaming:
  - Stimulus: 4 consecutive frames, continuous `in_valid`, `out_ready=1`.
  - Response: `in_ready` never drops; 256 outputs in natural order per frame with frame values offset by 64·f.
- Backpressure:
  - Stimulus: `out_ready=0`, feed 3 frames.
  - Response: `in_ready` falls after 128 accepts; the third frame stalls at sample 0.
  - Then raise `out_ready`: frames 0, 1, 2 emerge intact.
- Random stall:
  - Stimulus: random `in_valid`/`out_ready` (50%) over 20 frames.
  - Response: scoreboard matches, no loss or duplication, `out_data` stable during stall.
- Reset mid-frame:
  - Stimulus: after 30 accepts, pulse `rst`, then feed a full frame.
  - Response: `out_valid=0` immediately on `rst`; output is the new frame only.
- With `FFT_REORDER_LAST_EN`:
  - Stimulus: assert `in_last` on the 10th sample, then send a clean frame.
  - Response: `frame_err=1` sticky; the clean frame is output correctly; no output from the 10-sample fragment.
